c499_key_ctrl: RTL and testbench

C499_KEY_CTRL -- requirements
Module: c499_key_ctrl

---
 rtl/c499_key_ctrl.sv | 136 +++++++++++++
 tb/tb_c499_key_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/c499_key_ctrl.sv
// Serial key loader for the c499 locked netlist: shifts a framed key in, length/parity checks it,
// applies it and waits a settle time. Optional even-parity framing under C499_KEY_PARITY_EN.
module c499_key_ctrl #(
  parameter int unsigned KEY_W         = 31,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic             key_bit,
  input  logic             key_last,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_applied,
  output logic             key_err,
  output logic             busy
);

`ifdef C499_KEY_PARITY_EN
  localparam int unsigned PAR_W = 1;
`else
  localparam int unsigned PAR_W = 0;
`endif
  localparam int unsigned SH_W  = KEY_W + PAR_W;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned SET_W = 4;

  typedef enum logic [2:0] {IDLE, SHIFT, CHECK, SETTLE, DONE} state_t;

  state_t             state_q, state_d;
  logic [SH_W-1:0]    shadow_q, shadow_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SET_W-1:0]   set_q, set_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic               applied_q, applied_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;

  logic accept;
  logic len_ok;
  logic par_ok;

  assign key_ready   = ready_q;
  assign key_out     = key_q;
  assign key_applied = applied_q;
  assign key_err     = err_q;
  assign busy        = busy_q;

  assign accept = key_valid & ready_q;
  assign len_ok = (cnt_q == CNT_W'(SH_W));
`ifdef C499_KEY_PARITY_EN
  // Even parity: key bits plus trailing parity bit must XOR to zero
  assign par_ok = ~(^shadow_q);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      cnt_q     <= '0;
      set_q     <= '0;
      key_q     <= '0;
      applied_q <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      set_q     <= set_d;
      key_q     <= key_d;
      applied_q <= applied_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    set_d     = set_q;
    key_d     = key_q;
    applied_d = applied_q;
    err_d     = err_q;

    case (state_q)
      IDLE, DONE: begin
        // First bit of a new frame restarts the count and clears the previous status
        if (accept) begin
          shadow_d  = {shadow_q[SH_W-2:0], key_bit};
          cnt_d     = CNT_W'(1);
          err_d     = 1'b0;
          applied_d = 1'b0;
          state_d   = key_last ? CHECK : SHIFT;
        end
      end
      SHIFT: begin
        if (accept) begin
          shadow_d = {shadow_q[SH_W-2:0], key_bit};
          cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          if (key_last) state_d = CHECK;
        end
      end
      CHECK: begin
        if (len_ok && par_ok) begin
          key_d     = shadow_q[SH_W-1:PAR_W];
          applied_d = 1'b0;
          set_d     = '0;
          state_d   = SETTLE;
        end else begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (set_q == SET_W'(SETTLE_CYCLES - 1)) begin
          applied_d = 1'b1;
          state_d   = DONE;
        end else begin
          set_d = set_q + SET_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == SHIFT) || (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

endmodule

// File: tb/tb_c499_key_ctrl.sv
// Bench for c499_key_ctrl: table of frames with a result scoreboard, plus settle-pulse and mid-frame reset sequences.
module tb_c499_key_ctrl;
  localparam int KEY_W  = 31;
  localparam int SETTLE = 4;
`ifdef C499_KEY_PARITY_EN
  localparam int FL = KEY_W + 1;
  localparam logic [63:0] GOOD_BITS = 64'hB4B4B4B4;
  localparam logic [63:0] ALT_BITS  = 64'h26AF37BE;
`else
  localparam int FL = KEY_W;
  localparam logic [63:0] GOOD_BITS = 64'h5A5A5A5A;
  localparam logic [63:0] ALT_BITS  = 64'h13579BDF;
`endif
  localparam logic [30:0] GOOD_KEY = 31'h5A5A5A5A;
  localparam logic [30:0] ALT_KEY  = 31'h13579BDF;

  logic clk = 1'b0;
  logic rst, key_valid, key_bit, key_last;
  logic key_ready, key_applied, key_err, busy;
  logic [KEY_W-1:0] key_out;

  c499_key_ctrl #(.KEY_W(KEY_W), .SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_bit(key_bit), .key_last(key_last),
    .key_ready(key_ready), .key_out(key_out), .key_applied(key_applied),
    .key_err(key_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {logic [30:0] key; logic err; int cyc;} exp_t;
  typedef struct {int nbits; logic [63:0] bits; logic [30:0] key; logic err;} vec_t;

  exp_t sb[$];
  vec_t vt[8];
  int total = 0;
  int bad = 0;
  logic [30:0] model_key = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Each frame ends in exactly one rising key_err or key_applied; pop and compare there
  logic prev_app = 1'b0;
  logic prev_err = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ((key_applied && !prev_app) || (key_err && !prev_err))) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got err=%0b applied=%0b want no result", key_err, key_applied);
      end else begin
        e = sb.pop_front();
        check("res_key_out", 64'(key_out), 64'(e.key));
        check("res_key_err", 64'(key_err), 64'(e.err));
        check("res_applied", 64'(key_applied), 64'(!e.err));
        check("res_busy", 64'(busy), 64'(!e.err));
        check("res_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    prev_app = key_applied;
    prev_err = key_err;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_key_out"}, 64'(key_out), 64'd0);
    check({tag, "_applied"}, 64'(key_applied), 64'd0);
    check({tag, "_err"}, 64'(key_err), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'(key_ready), 64'd1);
  endtask

  // Sends bits[nbits-1] first; abort_at >= 0 asserts rst in place of that bit
  task automatic send_frame(input int nbits, input logic [63:0] bits, input logic [30:0] ekey,
                            input logic eerr, input int abort_at);
    for (int i = 0; i < nbits; i++) begin
      int g = 0;
      @(negedge clk);
      while (!key_ready && g < 100) begin
        @(negedge clk);
        g++;
      end
      if (!key_ready) begin
        total++;
        bad++;
        $display("FAIL ready_timeout: got key_ready=0 want 1 at bit %0d", i);
        key_valid = 1'b0;
        return;
      end
      if (i == abort_at) begin
        key_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        model_key = '0;
        return;
      end
      key_valid = 1'b1;
      key_bit   = bits[(nbits - 1 - i) % 64];
      key_last  = (i == nbits - 1);
      @(posedge clk);
      #1;
      if (i == 0) begin
        check("first_applied", 64'(key_applied), 64'd0);
        check("first_key_hold", 64'(key_out), 64'(model_key));
        check("first_busy", 64'(busy), 64'd1);
        check("first_err_clr", 64'(key_err), 64'd0);
      end
      if (i == nbits - 1) begin
        exp_t e;
        e.key = ekey;
        e.err = eerr;
        e.cyc = cyc + (eerr ? 1 : SETTLE + 1);
        sb.push_back(e);
        if (!eerr) model_key = ekey;
      end
    end
    @(negedge clk);
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (sb.size() != 0 && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
`ifdef C499_KEY_PARITY_EN
    vt[0] = '{32, 64'hB4B4B4B4, 31'h5A5A5A5A, 1'b0};
    vt[1] = '{31, 64'h12345678, 31'h5A5A5A5A, 1'b1};
    vt[2] = '{32, 64'h3,        31'h00000001, 1'b0};
    vt[3] = '{32, 64'h2,        31'h00000001, 1'b1};
    vt[4] = '{32, 64'hFFFFFFFF, 31'h7FFFFFFF, 1'b0};
    vt[5] = '{1,  64'h1,        31'h7FFFFFFF, 1'b1};
    vt[6] = '{70, 64'hA5A5A5A5_A5A5A5A5, 31'h7FFFFFFF, 1'b1};
    vt[7] = '{33, 64'h123456789, 31'h7FFFFFFF, 1'b1};
`else
    vt[0] = '{31, 64'h5A5A5A5A, 31'h5A5A5A5A, 1'b0};
    vt[1] = '{30, 64'h12345678, 31'h5A5A5A5A, 1'b1};
    vt[2] = '{31, 64'h7FFFFFFF, 31'h7FFFFFFF, 1'b0};
    vt[3] = '{1,  64'h1,        31'h7FFFFFFF, 1'b1};
    vt[4] = '{31, 64'h1,        31'h00000001, 1'b0};
    vt[5] = '{70, 64'hA5A5A5A5_A5A5A5A5, 31'h00000001, 1'b1};
    vt[6] = '{32, 64'hFFFFFFFF, 31'h00000001, 1'b1};
    vt[7] = '{31, 64'h2AAAAAAA, 31'h2AAAAAAA, 1'b0};
`endif
    rst = 1'b1;
    key_valid = 1'b0;
    key_bit = 1'b0;
    key_last = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    foreach (vt[k]) begin
      send_frame(vt[k].nbits, vt[k].bits, vt[k].key, vt[k].err, -1);
      drain();
    end

    // Bits offered during CHECK/SETTLE must be refused and leave the result untouched
    send_frame(FL, ALT_BITS, ALT_KEY, 1'b0, -1);
    for (int p = 0; p < 3; p++) begin
      key_valid = 1'b1;
      key_bit = 1'b1;
      key_last = 1'b1;
      @(negedge clk);
      check("settle_ready", 64'(key_ready), 64'd0);
      check("settle_busy", 64'(busy), 64'd1);
    end
    key_valid = 1'b0;
    key_last = 1'b0;
    drain();

    send_frame(FL, GOOD_BITS, GOOD_KEY, 1'b0, 15);
    send_frame(FL, GOOD_BITS, GOOD_KEY, 1'b0, -1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
